// File: rtl/wb_arbiter_n_pkg.sv
// Shared types and constants for the N-master Wishbone arbiter.
package wb_arbiter_n_pkg;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_BUSY = 1'b1
    } wb_state_e;

    localparam int ARB_FIXED  = 0;
    localparam int ARB_RR     = 1;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int MAX_M      = 8;

    // One-hot to binary index for up to MAX_M masters.
    function automatic logic [2:0] oh2idx(input logic [MAX_M-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < MAX_M; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arbiter_n_rr_pick.sv
// Combinational priority picker: fixed (lowest index) or round-robin from last_g+1.
module rr_pick #(
    parameter int NUM_M = 2,
    parameter int IDX_W = 1
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IDX_W-1:0] last_g_i,
    input  logic             rr_mode_i,
    output logic [NUM_M-1:0] winner_o
);

    logic found_s;
    int   idx_s;

    // Scan candidates in priority order and mark the first requester.
    always_comb begin
        winner_o = '0;
        found_s  = 1'b0;
        idx_s    = 0;
        for (int i = 0; i < NUM_M; i++) begin
            if (rr_mode_i) begin
                idx_s = (int'(last_g_i) + 1 + i) % NUM_M;
            end else begin
                idx_s = i;
            end
            for (int k = 0; k < NUM_M; k++) begin
                if (!found_s && (k == idx_s) && req_i[k]) begin
                    winner_o[k] = 1'b1;
                    found_s     = 1'b1;
                end else begin
                    winner_o[k] = winner_o[k];
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone classic arbiter; grant held for a whole cyc,
// with a per-strobe timeout that reports an error for unresponsive slaves.
module wb_arbiter_n
    import wb_arbiter_n_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RR_MODE = ARB_RR,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          m_cyc_i,
    input  logic [NUM_M-1:0]          m_stb_i,
    input  logic [NUM_M-1:0]          m_we_i,
    input  logic [NUM_M*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_M*DATA_W-1:0]   m_data_i,
    input  logic [NUM_M*DATA_W/8-1:0] m_sel_i,
    output logic [DATA_W-1:0]         m_data_o,
    output logic [NUM_M-1:0]          m_ack_o,
    output logic [NUM_M-1:0]          m_err_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_data_o,
    output logic [DATA_W/8-1:0]       s_sel_o,
    input  logic [DATA_W-1:0]         s_data_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    output logic [NUM_M-1:0]          grant_o
);

    localparam int IDX_W  = $clog2(NUM_M);
    localparam int SEL_W  = DATA_W / 8;
    localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TCNT_W-1:0] TC_LAST = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    wb_state_e          state_q, state_d;
    logic [NUM_M-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   last_g_q, last_g_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic [NUM_M-1:0]   winner_s;
    logic               busy_s, stb_raw_s, tout_s;

    rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (m_cyc_i),
        .last_g_i  (last_g_q),
        .rr_mode_i (RR_MODE != ARB_FIXED),
        .winner_o  (winner_s)
    );

    // State, grant, pointer and timeout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WB_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            last_g_q <= IDX_W'(NUM_M - 1);
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            last_g_q <= last_g_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign busy_s    = (state_q == WB_BUSY);
    assign stb_raw_s = busy_s & m_cyc_i[gidx_q] & m_stb_i[gidx_q];
    assign tout_s    = (TIMEOUT != 0) && stb_raw_s && !s_ack_i && !s_err_i && (tcnt_q == TC_LAST);

    // Next-state: arbitrate only from IDLE, release when the owner drops cyc.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        last_g_d = last_g_q;
        case (state_q)
            WB_IDLE: begin
                if (|m_cyc_i) begin
                    grant_d = winner_s;
                    gidx_d  = IDX_W'(oh2idx(MAX_M'(winner_s)));
                    state_d = WB_BUSY;
                end else begin
                    grant_d = '0;
                end
            end
            WB_BUSY: begin
                if (!m_cyc_i[gidx_q]) begin
                    grant_d  = '0;
                    last_g_d = gidx_q;
                    state_d  = WB_IDLE;
                end else begin
                    grant_d = grant_q;
                end
            end
            default: begin
                grant_d = '0;
                state_d = WB_IDLE;
            end
        endcase
    end

    // Timeout counter: runs while a strobe waits unanswered, clears when it fires.
    always_comb begin
        tcnt_d = '0;
        if ((TIMEOUT != 0) && stb_raw_s && !s_ack_i && !s_err_i && !tout_s) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end else begin
            tcnt_d = '0;
        end
    end

    // Slave-side mux of the granted master; responses steered by the one-hot grant.
    always_comb begin
        s_cyc_o  = busy_s & m_cyc_i[gidx_q];
        s_stb_o  = stb_raw_s & ~tout_s;
        s_we_o   = busy_s & m_we_i[gidx_q];
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        m_data_o = '0;
        if (busy_s) begin
            s_addr_o = m_addr_i[int'(gidx_q)*ADDR_W +: ADDR_W];
            s_data_o = m_data_i[int'(gidx_q)*DATA_W +: DATA_W];
            s_sel_o  = m_sel_i[int'(gidx_q)*SEL_W +: SEL_W];
            m_data_o = s_data_i;
        end else begin
            m_data_o = '0;
        end
    end

    // An ack or error arriving while reset is applied is not forwarded.
    assign m_ack_o = (busy_s && !rst && s_ack_i) ? grant_q : '0;
    assign m_err_o = (busy_s && !rst && (s_err_i || tout_s)) ? grant_q : '0;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench: instance A is 2-master fixed priority with TIMEOUT=8,
// instance B is 3-master round-robin.
module tb_wb_arbiter_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic [1:0]  a_cyc = '0, a_stb = '0, a_we = '0;
    logic [63:0] a_addr = '0, a_data = '0;
    logic [7:0]  a_sel = '0;
    logic [31:0] a_mdo, a_saddr, a_sdo;
    logic [31:0] a_sdi = '0;
    logic [1:0]  a_ack, a_err, a_grant;
    logic        a_scyc, a_sstb, a_swe;
    logic [3:0]  a_ssel;
    logic        a_sack = 1'b0, a_serr = 1'b0;

    logic [2:0]  b_cyc = '0, b_stb = '0, b_we = '0;
    logic [95:0] b_addr = '0, b_data = '0;
    logic [11:0] b_sel = '0;
    logic [31:0] b_mdo, b_saddr, b_sdo;
    logic [31:0] b_sdi = '0;
    logic [2:0]  b_ack, b_err, b_grant;
    logic        b_scyc, b_sstb, b_swe;
    logic [3:0]  b_ssel;
    logic        b_sack = 1'b0, b_serr = 1'b0;

    wb_arbiter_n #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(8)) u_a (
        .clk(clk), .rst(rst), .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we),
        .m_addr_i(a_addr), .m_data_i(a_data), .m_sel_i(a_sel), .m_data_o(a_mdo),
        .m_ack_o(a_ack), .m_err_o(a_err), .s_cyc_o(a_scyc), .s_stb_o(a_sstb),
        .s_we_o(a_swe), .s_addr_o(a_saddr), .s_data_o(a_sdo), .s_sel_o(a_ssel),
        .s_data_i(a_sdi), .s_ack_i(a_sack), .s_err_i(a_serr), .grant_o(a_grant)
    );

    wb_arbiter_n #(.NUM_M(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(255)) u_b (
        .clk(clk), .rst(rst), .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we),
        .m_addr_i(b_addr), .m_data_i(b_data), .m_sel_i(b_sel), .m_data_o(b_mdo),
        .m_ack_o(b_ack), .m_err_o(b_err), .s_cyc_o(b_scyc), .s_stb_o(b_sstb),
        .s_we_o(b_swe), .s_addr_o(b_saddr), .s_data_o(b_sdo), .s_sel_o(b_ssel),
        .s_data_i(b_sdi), .s_ack_i(b_sack), .s_err_i(b_serr), .grant_o(b_grant)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) tick;
        #1;
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL rst_a_grant: got %b exp 00", a_grant); end
        checks++; if (a_scyc !== 1'b0 || a_sstb !== 1'b0) begin errors++; $display("FAIL rst_a_slave: cyc=%b stb=%b exp 0", a_scyc, a_sstb); end
        checks++; if (a_ack !== 2'b00 || a_err !== 2'b00) begin errors++; $display("FAIL rst_a_resp: ack=%b err=%b exp 00", a_ack, a_err); end
        checks++; if (a_mdo !== 32'h0) begin errors++; $display("FAIL rst_a_mdo: got %h exp 0", a_mdo); end
        checks++; if (b_grant !== 3'b000) begin errors++; $display("FAIL rst_b_grant: got %b exp 000", b_grant); end
        rst = 1'b0;
        tick; #1;
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL idle_no_req: got %b exp 00", a_grant); end
    endtask

    task automatic test_fixed_priority;
        tick; a_cyc = 2'b11; a_stb = 2'b11; #1;
        checks++; if (a_grant !== 2'b00 || a_scyc !== 1'b0) begin errors++; $display("FAIL fix_latency: grant=%b scyc=%b exp 00/0", a_grant, a_scyc); end
        tick; #1;
        checks++; if (a_grant !== 2'b01 || a_scyc !== 1'b1) begin errors++; $display("FAIL fix_grant0: grant=%b scyc=%b exp 01/1", a_grant, a_scyc); end
        // master 0 drops cyc together with its ack
        a_sack = 1'b1; a_cyc = 2'b10; a_stb = 2'b10; #1;
        checks++; if (a_ack !== 2'b01) begin errors++; $display("FAIL fix_ack_on_drop: got %b exp 01", a_ack); end
        checks++; if (a_scyc !== 1'b0) begin errors++; $display("FAIL fix_cyc_drop: got %b exp 0", a_scyc); end
        tick; a_sack = 1'b0; #1;
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL fix_dead_cycle: got %b exp 00", a_grant); end
        tick; #1;
        checks++; if (a_grant !== 2'b10 || a_ack !== 2'b00) begin errors++; $display("FAIL fix_grant1: grant=%b ack=%b exp 10/00", a_grant, a_ack); end
        a_sack = 1'b1; a_cyc = 2'b00; a_stb = 2'b00; #1;
        checks++; if (a_ack !== 2'b10) begin errors++; $display("FAIL fix_ack1: got %b exp 10", a_ack); end
        tick; a_sack = 1'b0; #1;
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL fix_release1: got %b exp 00", a_grant); end
    endtask

    task automatic test_block;
        tick; a_cyc = 2'b11; a_stb = 2'b11;
        tick; #1;
        checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL blk_grant0: got %b exp 01", a_grant); end
        for (int b = 0; b < 4; b++) begin
            if (b > 0) tick;
            a_sack = 1'b1; #1;
            checks++; if (a_ack !== 2'b01 || a_grant !== 2'b01) begin errors++; $display("FAIL blk_beat%0d: ack=%b grant=%b exp 01/01", b, a_ack, a_grant); end
        end
        tick; a_sack = 1'b0; a_cyc = 2'b10; a_stb = 2'b10; #1;
        checks++; if (a_scyc !== 1'b0 || a_ack !== 2'b00) begin errors++; $display("FAIL blk_end: scyc=%b ack=%b exp 0/00", a_scyc, a_ack); end
        tick; #1;
        checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL blk_dead: got %b exp 00", a_grant); end
        tick; #1;
        checks++; if (a_grant !== 2'b10) begin errors++; $display("FAIL blk_grant1: got %b exp 10", a_grant); end
        a_cyc = 2'b00; a_stb = 2'b00;
        tick; tick;
    endtask

    task automatic test_read_write;
        a_cyc = 2'b10; a_stb = 2'b10; a_we = 2'b10;
        a_addr = {32'h3000_0010, 32'h0000_0000};
        a_data = {32'hCAFE_F00D, 32'h0000_0000};
        a_sel  = {4'b0011, 4'b0000};
        tick; #1;
        checks++; if (a_grant !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b exp 10", a_grant); end
        checks++; if (a_saddr !== 32'h3000_0010 || a_ssel !== 4'b0011) begin errors++; $display("FAIL wr_addr_sel: addr=%h sel=%b exp 30000010/0011", a_saddr, a_ssel); end
        checks++; if (a_swe !== 1'b1 || a_sdo !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_we_data: we=%b data=%h exp 1/cafef00d", a_swe, a_sdo); end
        a_sack = 1'b1; a_cyc = 2'b00; a_stb = 2'b00; a_we = 2'b00; #1;
        checks++; if (a_ack !== 2'b10) begin errors++; $display("FAIL wr_ack: got %b exp 10", a_ack); end
        tick; a_sack = 1'b0;
        a_cyc = 2'b01; a_stb = 2'b01; a_addr = {32'h0000_0000, 32'h1000_0004};
        tick; #1;
        checks++; if (a_grant !== 2'b01 || a_swe !== 1'b0 || a_saddr !== 32'h1000_0004) begin errors++; $display("FAIL rd_req: grant=%b we=%b addr=%h exp 01/0/10000004", a_grant, a_swe, a_saddr); end
        a_sdi = 32'hDEAD_BEEF; a_sack = 1'b1; a_cyc = 2'b00; a_stb = 2'b00; #1;
        checks++; if (a_mdo !== 32'hDEAD_BEEF || a_ack !== 2'b01) begin errors++; $display("FAIL rd_data: data=%h ack=%b exp deadbeef/01", a_mdo, a_ack); end
        tick; a_sack = 1'b0; a_sdi = 32'h0; #1;
        checks++; if (a_grant !== 2'b00 || a_mdo !== 32'h0) begin errors++; $display("FAIL rd_release: grant=%b data=%h exp 00/0", a_grant, a_mdo); end
    endtask

    task automatic test_timeout;
        a_cyc = 2'b01; a_stb = 2'b01;
        tick;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick;
            #1;
            checks++; if (a_err !== 2'b00 || a_sstb !== 1'b1) begin errors++; $display("FAIL to_wait%0d: err=%b stb=%b exp 00/1", k, a_err, a_sstb); end
        end
        tick; #1;
        checks++; if (a_err !== 2'b01) begin errors++; $display("FAIL to_err: got %b exp 01", a_err); end
        checks++; if (a_sstb !== 1'b0 || a_scyc !== 1'b1) begin errors++; $display("FAIL to_stb_low: stb=%b cyc=%b exp 0/1", a_sstb, a_scyc); end
        tick; #1;
        checks++; if (a_err !== 2'b00 || a_sstb !== 1'b1) begin errors++; $display("FAIL to_pulse_once: err=%b stb=%b exp 00/1", a_err, a_sstb); end
        a_cyc = 2'b00; a_stb = 2'b00;
        tick; tick;
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
        b_cyc = 3'b111; b_stb = 3'b111;
        for (int n = 0; n < 4; n++) begin
            tick; #1;
            checks++; if (b_grant !== exp_seq[n]) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", n, b_grant, exp_seq[n]); end
            b_sack = 1'b1; b_cyc = ~exp_seq[n]; b_stb = ~exp_seq[n]; #1;
            checks++; if (b_ack !== exp_seq[n]) begin errors++; $display("FAIL rr_ack%0d: got %b exp %b", n, b_ack, exp_seq[n]); end
            tick; b_sack = 1'b0; b_cyc = 3'b111; b_stb = 3'b111; #1;
            checks++; if (b_grant !== 3'b000) begin errors++; $display("FAIL rr_dead%0d: got %b exp 000", n, b_grant); end
        end
    endtask

    task automatic test_reset_mid;
        tick; #1;
        checks++; if (b_grant !== 3'b010 || b_sstb !== 1'b1) begin errors++; $display("FAIL rm_busy: grant=%b stb=%b exp 010/1", b_grant, b_sstb); end
        rst = 1'b1; b_sack = 1'b1; #1;
        checks++; if (b_ack !== 3'b000) begin errors++; $display("FAIL rm_ack_blocked: got %b exp 000", b_ack); end
        tick; rst = 1'b0; b_sack = 1'b0; #1;
        checks++; if (b_scyc !== 1'b0 || b_grant !== 3'b000) begin errors++; $display("FAIL rm_dropped: cyc=%b grant=%b exp 0/000", b_scyc, b_grant); end
        tick; #1;
        checks++; if (b_grant !== 3'b001) begin errors++; $display("FAIL rm_first_winner: got %b exp 001", b_grant); end
        b_cyc = 3'b000; b_stb = 3'b000;
        tick; tick;
    endtask

    initial begin
        test_reset;
        test_fixed_priority;
        test_block;
        test_read_write;
        test_timeout;
        test_round_robin;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
